// File: rtl/adc_responder.sv
// Slave end of the 16-clock serial ADC frame: captures a channel address on din and shifts a 12-bit sample out on dout.
// Optional build macro ADC_RESPONDER_RAMP_EN: each latched channel register post-increments (a write in the same cycle wins).
module adc_responder #(
    parameter int CH_W   = 3,
    parameter int DATA_W = 12
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              din,
    output logic              dout,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    output logic [CH_W-1:0]   cur_ch,
    output logic              frame_done
);

    localparam int NUM_CH = 1 << CH_W;

    localparam logic [3:0] CNT_ADDR_FIRST = 4'd2;
    localparam logic [3:0] CNT_ADDR_LAST  = 4'd4;
    localparam logic [3:0] CNT_LATCH      = 4'd3;
    localparam logic [3:0] CNT_SHIFT_LAST = 4'd14;
    localparam logic [3:0] CNT_LAST       = 4'd15;

    logic [3:0]        cnt_q,        cnt_d;
    logic [CH_W-1:0]   addr_q,       addr_d;
    logic [CH_W-1:0]   cur_ch_q,     cur_ch_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic              dout_q,       dout_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] ch_reg_q [NUM_CH];
    logic [DATA_W-1:0] ch_reg_d [NUM_CH];

    always_comb begin
        cnt_d        = cnt_q + 4'd1;
        addr_d       = addr_q;
        cur_ch_d     = cur_ch_q;
        shift_d      = shift_q;
        dout_d       = 1'b0;
        frame_done_d = (cnt_q == CNT_SHIFT_LAST);
        ch_reg_d     = ch_reg_q;

        if (cnt_q >= CNT_ADDR_FIRST && cnt_q <= CNT_ADDR_LAST) begin
            addr_d = {addr_q[CH_W-2:0], din};
        end

        // The address completed this frame is the channel converted in the next one.
        if (cnt_q == CNT_LAST) begin
            cur_ch_d = addr_q;
        end

        if (cnt_q == CNT_LATCH) begin
            shift_d = ch_reg_q[cur_ch_q];
            dout_d  = shift_d[DATA_W-1];
        end else if (cnt_q > CNT_LATCH && cnt_q <= CNT_SHIFT_LAST) begin
            shift_d = shift_q << 1;
            dout_d  = shift_d[DATA_W-1];
        end

`ifdef ADC_RESPONDER_RAMP_EN
        if (cnt_q == CNT_LATCH) begin
            ch_reg_d[cur_ch_q] = ch_reg_q[cur_ch_q] + DATA_W'(1);
        end
`endif

        // Applied last so a host write overrides any ramp increment.
        if (wr_en) begin
            ch_reg_d[wr_ch] = wr_data;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            cur_ch_q     <= '0;
            shift_q      <= '0;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                ch_reg_q[k] <= DATA_W'(k * 256);
            end
        end else begin
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            cur_ch_q     <= cur_ch_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < NUM_CH; k++) begin
                ch_reg_q[k] <= ch_reg_d[k];
            end
        end
    end

    assign dout       = dout_q;
    assign cur_ch     = cur_ch_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: frame-level reference model checked every cycle, plus directed frames with literal sample words.
module tb_adc_responder;

  logic        sclk;
  logic        rst;
  logic        din;
  logic        dout;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [11:0] wr_data;
  logic [2:0]  cur_ch;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  adc_responder dut (
    .sclk       (sclk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .cur_ch     (cur_ch),
    .frame_done (frame_done)
  );

  // clock / reset
  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: frame position, channel contents, the word being sent
  int          m_pos;
  logic [11:0] m_ch [8];
  logic [2:0]  m_addr;
  logic [2:0]  m_cur;
  logic [11:0] m_sample;
  bit          model_on = 1'b0;

  initial begin
    forever begin
      @(posedge sclk);
      if (rst) begin
        m_pos    = 0;
        for (int k = 0; k < 8; k++) m_ch[k] = 12'(k * 256);
        m_addr   = 3'd0;
        m_cur    = 3'd0;
        m_sample = 12'd0;
      end else begin
        if (m_pos >= 2 && m_pos <= 4) m_addr = {m_addr[1:0], din};
        if (m_pos == 3) begin
          m_sample = m_ch[m_cur];
`ifdef ADC_RESPONDER_RAMP_EN
          m_ch[m_cur] = m_ch[m_cur] + 12'd1;
`endif
        end
        if (m_pos == 15) m_cur = m_addr;
        if (wr_en) m_ch[wr_ch] = wr_data;
        m_pos = (m_pos + 1) % 16;
      end
      model_on = 1'b1;
    end
  end

  // compare process: outputs against the model every cycle
  initial begin
    logic exp_dout;
    forever begin
      @(negedge sclk);
      if (model_on) begin
        exp_dout = 1'b0;
        if (m_pos >= 4) exp_dout = m_sample[15 - m_pos];
        chk("model_dout", int'(dout), int'(exp_dout));
        chk("model_cur_ch", int'(cur_ch), int'(m_cur));
        chk("model_frame_done", int'(frame_done), (m_pos == 15) ? 1 : 0);
      end
    end
  end

  // driver: one full frame starting at the negedge where cnt = 0
  task automatic run_frame(input logic [2:0] addr, input bit do_wr, input int wr_p,
                           input logic [2:0] wc, input logic [11:0] wd,
                           output logic [11:0] word, output int fd_pos, output logic [2:0] cur_mid);
    word    = 12'd0;
    fd_pos  = -1;
    cur_mid = 3'd0;
    for (int p = 0; p < 16; p++) begin
      if (p >= 4) word[15 - p] = dout;
      if (frame_done) fd_pos = (fd_pos < 0) ? p : 99;
      if (p == 8) cur_mid = cur_ch;
      din     = (p >= 2 && p <= 4) ? addr[4 - p] : 1'b0;
      wr_en   = do_wr && (p == wr_p);
      wr_ch   = wc;
      wr_data = wd;
      @(negedge sclk);
    end
    wr_en = 1'b0;
    din   = 1'b0;
  endtask

  // scoreboard of literal frame words
  logic [11:0] exp_q [$];

  task automatic frame_chk(input string name, input logic [2:0] addr, input bit do_wr, input int wr_p,
                           input logic [2:0] wc, input logic [11:0] wd, input logic [11:0] exp_word);
    logic [11:0] word;
    int          fd_pos;
    logic [2:0]  cur_mid;
    logic [11:0] exp_w;
    exp_q.push_back(exp_word);
    run_frame(addr, do_wr, wr_p, wc, wd, word, fd_pos, cur_mid);
    exp_w = exp_q.pop_front();
    chk(name, int'(word), int'(exp_w));
    chk({name, "_fd_pos"}, fd_pos, 15);
  endtask

  initial begin
    logic [11:0] word;
    int          fd_pos;
    logic [2:0]  cur_mid;

    rst = 1'b1; din = 1'b0; wr_en = 1'b0; wr_ch = 3'd0; wr_data = 12'd0;
    @(negedge sclk);
    @(negedge sclk);
    chk("reset_dout", int'(dout), 0);
    chk("reset_cur_ch", int'(cur_ch), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    rst = 1'b0;

    run_frame(3'd0, 1'b0, 0, 3'd0, 12'd0, word, fd_pos, cur_mid);
    chk("f0_word", int'(word), 'h000);
    chk("f0_fd_pos", fd_pos, 15);
    chk("f0_cur", int'(cur_mid), 0);
`ifdef ADC_RESPONDER_RAMP_EN
    frame_chk("f1_word", 3'd5, 1'b0, 0, 3'd0, 12'd0, 12'h001);
`else
    frame_chk("f1_word", 3'd5, 1'b0, 0, 3'd0, 12'd0, 12'h000);
`endif
    run_frame(3'd0, 1'b0, 0, 3'd0, 12'd0, word, fd_pos, cur_mid);
    chk("f2_word_ch5", int'(word), 'h500);
    chk("f2_cur", int'(cur_mid), 5);

    // channel 3 written, then addressed twice
`ifdef ADC_RESPONDER_RAMP_EN
    frame_chk("f3_word", 3'd3, 1'b1, 0, 3'd3, 12'hA5C, 12'h002);
`else
    frame_chk("f3_word", 3'd3, 1'b1, 0, 3'd3, 12'hA5C, 12'h000);
`endif
    frame_chk("f4_word_ch3", 3'd3, 1'b0, 0, 3'd0, 12'd0, 12'hA5C);
`ifdef ADC_RESPONDER_RAMP_EN
    frame_chk("f5_word_ch3", 3'd7, 1'b1, 0, 3'd7, 12'hFFF, 12'hA5D);
`else
    frame_chk("f5_word_ch3", 3'd7, 1'b1, 0, 3'd7, 12'hFFF, 12'hA5C);
`endif
    frame_chk("f6_word_ch7", 3'd7, 1'b0, 0, 3'd0, 12'd0, 12'hFFF);
`ifdef ADC_RESPONDER_RAMP_EN
    frame_chk("f7_word_ch7", 3'd2, 1'b0, 0, 3'd0, 12'd0, 12'h000);
`else
    frame_chk("f7_word_ch7", 3'd2, 1'b0, 0, 3'd0, 12'd0, 12'hFFF);
`endif

    // write to the channel being latched on the cnt = 3 edge
    frame_chk("f8_collision_old", 3'd0, 1'b1, 3, 3'd2, 12'h123, 12'h200);
`ifdef ADC_RESPONDER_RAMP_EN
    frame_chk("f9_word_ch0", 3'd2, 1'b0, 0, 3'd0, 12'd0, 12'h003);
`else
    frame_chk("f9_word_ch0", 3'd2, 1'b0, 0, 3'd0, 12'd0, 12'h000);
`endif
    run_frame(3'd6, 1'b0, 0, 3'd0, 12'd0, word, fd_pos, cur_mid);
    chk("f10_collision_new", int'(word), 'h123);
    chk("f10_cur", int'(cur_mid), 2);

    // partial frame on channel 6, reset asserted while cnt = 9
    for (int p = 0; p < 9; p++) @(negedge sclk);
    chk("partial_cur", int'(cur_ch), 6);
    rst = 1'b1;
    @(negedge sclk);
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_cur", int'(cur_ch), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    rst = 1'b0;

    frame_chk("f12_after_rst", 3'd1, 1'b0, 0, 3'd0, 12'd0, 12'h000);
    frame_chk("f13_word_ch1", 3'd4, 1'b0, 0, 3'd0, 12'd0, 12'h100);
    frame_chk("f14_word_ch4", 3'd0, 1'b0, 0, 3'd0, 12'd0, 12'h400);

    @(negedge sclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
